// File: rtl/y_row_reader.sv
// Fetches one Y-matrix row from the Y SRAM and streams its non-empty slots as
// column/{real,imag} entries over a valid/ready handshake.
module y_row_reader #(
  parameter int          WORDS_PER_ROW = 4,
  parameter logic [15:0] EMPTY_COL     = 16'hFFFF
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [15:0]  rowIndex,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [10:0]  yReadAddress,
  input  logic [255:0] yReadData,
  output logic         opValid,
  input  logic         opReady,
  output logic [15:0]  opCol,
  output logic [47:0]  opVal,
  output logic [7:0]   entryCount
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_CAPT, S_EMIT, S_DONE} state_t;

  state_t         state_q;
  logic           busy_q, done_q, error_q;
  logic [10:0]    addr_q;
  logic [7:0]     count_q;
  logic [4:0]     word_q;
  logic [1:0]     slot_q;
  logic [255:0]   buf_q;

  logic [31:0]    row_prod;
  logic           out_of_range;
  logic [63:0]    slot_word;
  logic           slot_empty;
  logic           last_word;
  logic           xfer;

  // Range test uses the full-width product; only the low 11 bits address the SRAM.
  assign row_prod     = 32'(rowIndex) * 32'(WORDS_PER_ROW);
  assign out_of_range = row_prod > 32'd2047;
  assign last_word    = word_q == 5'(WORDS_PER_ROW - 1);

  assign slot_word  = buf_q[{slot_q, 6'd0} +: 64];
  assign slot_empty = slot_word[63:48] == EMPTY_COL;
  assign opValid    = (state_q == S_EMIT) && !slot_empty;
  assign opCol      = opValid ? slot_word[63:48] : 16'd0;
  assign opVal      = opValid ? slot_word[47:0]  : 48'd0;
  assign xfer       = opValid && opReady;

  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign yReadAddress = addr_q;
  assign entryCount   = count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      addr_q  <= 11'd0;
      count_q <= 8'd0;
      word_q  <= 5'd0;
      slot_q  <= 2'd0;
      buf_q   <= '1;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            busy_q  <= 1'b1;
            count_q <= 8'd0;
            word_q  <= 5'd0;
            if (out_of_range) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              error_q <= 1'b1;
            end else begin
              addr_q  <= row_prod[10:0];
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: state_q <= S_CAPT;
        S_CAPT: begin
          buf_q   <= yReadData;
          slot_q  <= 2'd0;
          state_q <= S_EMIT;
        end
        S_EMIT: begin
          // The first empty slot terminates the row; later slots are never looked at.
          if (slot_empty) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else if (xfer) begin
            count_q <= count_q + 8'd1;
            if (slot_q != 2'd3) begin
              slot_q <= slot_q + 2'd1;
            end else if (last_word) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              addr_q  <= addr_q + 11'd1;
              word_q  <= word_q + 5'd1;
              state_q <= S_WAIT;
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_y_row_reader.sv
// Directed bench for y_row_reader with a one-cycle-latency SRAM model.
module tb_y_row_reader;

  logic         clock;
  logic         reset;
  logic         start;
  logic [15:0]  rowIndex;
  logic         busy, done, error;
  logic [10:0]  yReadAddress;
  logic [255:0] yReadData;
  logic         opValid, opReady;
  logic [15:0]  opCol;
  logic [47:0]  opVal;
  logic [7:0]   entryCount;

  int nchecks = 0;
  int nerrors = 0;

  logic [255:0] mem [0:2047];

  y_row_reader #(.WORDS_PER_ROW(4), .EMPTY_COL(16'hFFFF)) dut (
    .clock(clock), .reset(reset), .start(start), .rowIndex(rowIndex),
    .busy(busy), .done(done), .error(error), .yReadAddress(yReadAddress),
    .yReadData(yReadData), .opValid(opValid), .opReady(opReady),
    .opCol(opCol), .opVal(opVal), .entryCount(entryCount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) yReadData <= mem[yReadAddress];

  function automatic logic [63:0] full_slot(input int n);
    return {16'(100 + n), 24'(n + 1), 24'(n * 3)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerrors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present start for one edge; returns sampling in cycle 1.
  task automatic begin_row(input logic [15:0] row);
    start    = 1'b1;
    rowIndex = row;
    tick();
    start    = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"},  64'(busy), 64'd0);
    chk({tag, "_done"},  64'(done), 64'd0);
    chk({tag, "_error"}, 64'(error), 64'd0);
    chk({tag, "_opValid"}, 64'(opValid), 64'd0);
    chk({tag, "_addr"},  64'(yReadAddress), 64'd0);
    chk({tag, "_opCol"}, 64'(opCol), 64'd0);
    chk({tag, "_opVal"}, 64'(opVal), 64'd0);
    chk({tag, "_count"}, 64'(entryCount), 64'd0);
  endtask

  initial begin
    int n, donecyc, maxaddr, minaddr;
    for (int a = 0; a < 2048; a++) mem[a] = '1;
    mem[20] = {64'hFFFF_FFFF_FFFF_FFFF,
               {16'd9, 24'h000300, 24'h000003},
               {16'd7, 24'h000200, 24'h000002},
               {16'd3, 24'h000100, 24'hFFFF00}};
    for (int w = 0; w < 4; w++)
      mem[4 + w] = {full_slot(4*w + 3), full_slot(4*w + 2), full_slot(4*w + 1), full_slot(4*w)};

    reset = 1'b1; start = 1'b0; rowIndex = 16'd0; opReady = 1'b1;
    tick(); tick(); tick();
    chk_reset_vals("rst");
    reset = 1'b0;
    tick();

    // Empty row 2
    begin_row(16'd2);
    chk("empty_addr", 64'(yReadAddress), 64'd8);
    chk("empty_busy_c1", 64'(busy), 64'd1);
    chk("empty_vld_c1", 64'(opValid), 64'd0);
    tick();
    chk("empty_vld_c2", 64'(opValid), 64'd0);
    tick();
    chk("empty_vld_c3", 64'(opValid), 64'd0);
    chk("empty_done_c3", 64'(done), 64'd0);
    tick();
    chk("empty_done_c4", 64'(done), 64'd1);
    chk("empty_err_c4", 64'(error), 64'd0);
    chk("empty_vld_c4", 64'(opValid), 64'd0);
    tick();
    chk("empty_busy_c5", 64'(busy), 64'd0);
    chk("empty_done_c5", 64'(done), 64'd0);
    chk("empty_count", 64'(entryCount), 64'd0);

    // Partial row 5, with a start pulse while busy that must be ignored
    opReady = 1'b1;
    begin_row(16'd5);
    chk("part_addr", 64'(yReadAddress), 64'd20);
    start = 1'b1; rowIndex = 16'd2;
    tick();
    start = 1'b0;
    tick();
    chk("part_vld_c3", 64'(opValid), 64'd1);
    chk("part_col_c3", 64'(opCol), 64'd3);
    chk("part_val_c3", 64'(opVal), 64'h000100FFFF00);
    tick();
    chk("part_col_c4", 64'(opCol), 64'd7);
    tick();
    chk("part_col_c5", 64'(opCol), 64'd9);
    chk("part_val_c5", 64'(opVal), 64'h000300000003);
    tick();
    chk("part_vld_c6", 64'(opValid), 64'd0);
    chk("part_done_c6", 64'(done), 64'd0);
    tick();
    chk("part_done_c7", 64'(done), 64'd1);
    chk("part_count", 64'(entryCount), 64'd3);
    tick();
    chk("part_busy_c8", 64'(busy), 64'd0);
    chk("part_count_hold", 64'(entryCount), 64'd3);

    // Backpressure on the first entry of row 5
    opReady = 1'b0;
    begin_row(16'd5);
    tick(); tick();
    for (int k = 0; k < 5; k++) begin
      chk("bp_vld", 64'(opValid), 64'd1);
      chk("bp_col", 64'(opCol), 64'd3);
      chk("bp_val", 64'(opVal), 64'h000100FFFF00);
      chk("bp_count", 64'(entryCount), 64'd0);
      tick();
    end
    opReady = 1'b1;
    chk("bp_col_c8", 64'(opCol), 64'd3);
    tick();
    chk("bp_col_c9", 64'(opCol), 64'd7);
    chk("bp_count_c9", 64'(entryCount), 64'd1);
    tick(); tick(); tick();
    chk("bp_done_c12", 64'(done), 64'd1);
    chk("bp_count_end", 64'(entryCount), 64'd3);
    tick();

    // Full row 1 spanning four words
    opReady = 1'b1;
    begin_row(16'd1);
    n = 0; donecyc = -1; maxaddr = 0; minaddr = 2047;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (int'(yReadAddress) > maxaddr) maxaddr = int'(yReadAddress);
      if (int'(yReadAddress) < minaddr) minaddr = int'(yReadAddress);
      if (opValid) begin
        chk("full_col", 64'(opCol), 64'(100 + n));
        chk("full_val", 64'(opVal), 64'(full_slot(n) & 64'h0000_FFFF_FFFF_FFFF));
        chk("full_cycle", 64'(cyc), 64'(3 + n + 2*(n/4)));
        n++;
      end
      if (done) begin
        donecyc = cyc;
        break;
      end
      tick();
    end
    chk("full_ntransfers", 64'(n), 64'd16);
    chk("full_done_cycle", 64'(donecyc), 64'd25);
    chk("full_max_addr", 64'(maxaddr), 64'd7);
    chk("full_min_addr", 64'(minaddr), 64'd4);
    chk("full_count", 64'(entryCount), 64'd16);
    tick();

    // Out-of-range row
    begin_row(16'd600);
    chk("oor_done_c1", 64'(done), 64'd1);
    chk("oor_err_c1", 64'(error), 64'd1);
    chk("oor_busy_c1", 64'(busy), 64'd1);
    chk("oor_vld_c1", 64'(opValid), 64'd0);
    chk("oor_count_c1", 64'(entryCount), 64'd0);
    tick();
    chk("oor_busy_c2", 64'(busy), 64'd0);
    chk("oor_done_c2", 64'(done), 64'd0);
    chk("oor_err_c2", 64'(error), 64'd0);

    // Reset during the second transfer of row 5
    opReady = 1'b1;
    begin_row(16'd5);
    tick(); tick(); tick();
    chk("rstmid_col_c4", 64'(opCol), 64'd7);
    reset = 1'b1;
    tick();
    chk_reset_vals("rstmid");
    reset = 1'b0;
    tick();
    chk("rstmid_done_after", 64'(done), 64'd0);
    chk("rstmid_busy_after", 64'(busy), 64'd0);
    begin_row(16'd5);
    chk("rerun_addr", 64'(yReadAddress), 64'd20);
    tick(); tick();
    chk("rerun_col_c3", 64'(opCol), 64'd3);
    tick(); tick(); tick(); tick();
    chk("rerun_done_c7", 64'(done), 64'd1);
    chk("rerun_count", 64'(entryCount), 64'd3);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
